clock_setter: RTL
=================

Name: clock_setter

Overview:
Button-driven front end that produces the load interface of the alarm clock core: H_in1/H_in0/M_in1/M_in0 BCD digits plus single-cycle LD_time/LD_alarm strobes. The user edits the time or the alarm field by field with up/down/select/mode buttons. The block runs on the same 1 Hz tick domain as the clock's counters, so each load strobe is seen by the clock core exactly once.

Parameters:
TIMEOUT, 10, number of consecutive clk_1s cycles with no button edge after which an edit session is abandoned (range 2..63).

Ports:
clk_1s  input  1  1 Hz tick clock (rising edge).
reset  input  1  asynchronous, active-high.
btn_mode  input  1  debounced level; rising edge = switch mode.
btn_sel  input  1  debounced level; rising edge = next field / commit.
btn_up  input  1  debounced level; rising edge = increment field.
btn_down  input  1  debounced level; rising edge = decrement field.
cur_h1  input  2  current time hour tens (BCD), used to seed time edit.
cur_h0  input  4  current time hour units.
cur_m1  input  4  current time minute tens.
cur_m0  input  4  current time minute units.
H_in1  output  2  hour tens to clock core.
H_in0  output  4  hour units.
M_in1  output  4  minute tens.
M_in0  output  4  minute units.
LD_time  output  1  one-cycle load-time strobe.
LD_alarm  output  1  one-cycle load-alarm strobe.
edit_active  output  1  high in any edit state.
edit_field  output  2  0 none, 1 hour, 2 minute.

Behaviour:
- Edge detect: each button is registered once per cycle; edge = current level high and previous level low. A held button yields one edge only.
- FSM states: IDLE, T_HOUR, T_MIN, A_HOUR, A_MIN, LOAD.
- Per-cycle priority: mode > sel > up/down. Up and down together = no change.
- IDLE, mode edge -> T_HOUR. Edit regs are seeded from cur_*; hour >23 or minute >59 seeds 00.
- T_HOUR/T_MIN, mode edge -> A_HOUR. Edit regs are seeded from the alarm shadow register.
- A_HOUR/A_MIN, mode edge -> IDLE. Edit is discarded.
- Sel edge: *_HOUR -> *_MIN; *_MIN -> LOAD (records target time or alarm).
- Up/down in HOUR state: hour ±1 mod 24, so 23->00 and 00->23. Minutes are unaffected.
- Up/down in MIN state: minute ±1 mod 60, so 59->00 and 00->59. There is no carry into hours.
- Arithmetic is done directly on BCD digits, e.g. 09->10 and 10->09, 19->20, 20->19.
- LOAD lasts exactly one cycle:
  - Outputs H_in*/M_in* = edit value.
  - LD_time=1 (time target) or LD_alarm=1 (alarm target), never both.
  - Alarm target also updates the alarm shadow.
  - Next state IDLE. Buttons seen during LOAD are ignored.
- Timeout:
  - The inactivity counter clears on any button edge and on entry to an edit state.
  - It increments every cycle in edit states.
  - When it reaches TIMEOUT-1 with no edge that cycle -> IDLE, no strobe, edit discarded.
- H_in*/M_in* are registered. In edit states they track the edit regs. In IDLE they hold the last loaded value.
- LD_time and LD_alarm are registered, high only in the LOAD cycle.
- edit_field: 1 in *_HOUR, 2 in *_MIN, else 0.
- Reset, asynchronous, at any point including mid-edit or LOAD:
  - State IDLE.
  - H_in*/M_in*, edit regs and alarm shadow = 00:00.
  - LD_time=LD_alarm=0, edit_active=0, edit_field=0.
  - Edge history regs = 0, so a button held through reset produces an edge on the first cycle after release of reset.

Decomposition:
- Shared package clock_pkg holds:
  - State encoding enum (6 states, 3 bits).
  - Constants MAX_HOUR=23, MAX_MIN=59.
  - Field codes FIELD_NONE/HOUR/MIN.
- Sub-module bcd_wrap_counter: loadable two-digit BCD up/down counter with parameter MAX (23 or 59) and wrap. It is instantiated twice, for hour and minute edit regs.
- Button edge detection stays inline.

Test Plan:
- Time set: reset; cur=07:30; mode, up×3, sel, down×31, sel.
  -> LD_time one cycle, outputs 10:59; LD_alarm=0 throughout; edit_active then 0.
- Wrap: in T_HOUR seeded 23:xx, up -> 00; down -> 23. In T_MIN seeded 00, down -> 59; up -> 00, hour unchanged.
- Alarm set: mode, mode, up×6, sel, up×5, sel.
  -> LD_alarm pulse, outputs 06:05.
  Re-enter alarm edit afterwards -> edit regs seed 06:05.
- Timeout: enter T_HOUR, up once, then idle 10 cycles with TIMEOUT=10.
  -> returns to IDLE, no strobe, outputs keep the prior value.
- Priority/simultaneity: up+down same cycle -> unchanged. Mode+sel same cycle in T_MIN -> A_HOUR, no LOAD. Held btn_up for 5 cycles -> single increment.
- Reset mid-edit: assert reset during T_MIN after edits.
  -> immediately IDLE, outputs 00:00, strobes 0; no stray LD after deassert.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm clock setter.
// State encoding, BCD limits, field codes, seed validity check.
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T_HOUR = 3'd1,
    T_MIN  = 3'd2,
    A_HOUR = 3'd3,
    A_MIN  = 3'd4,
    LOAD   = 3'd5
  } state_t;

  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;

  // True when tens/units form a legal BCD value not above max.
  function automatic logic bcd_ok(
    input logic [3:0] t,
    input logic [3:0] u,
    input int         max
  );
    return (u <= 4'd9) &&
           ((int'(t) * 10 + int'(u)) <= max);
  endfunction

endpackage

// File: rtl/clock_setter_bcd_wrap_counter.sv
// Loadable two-digit BCD up/down counter that wraps 0..MAX.
// Exposes the next value so the owner can register it in step.
module bcd_wrap_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59,
  parameter int TW  = 4
) (
  input  logic          clk_1s,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] ld1,
  input  logic [3:0]    ld0,
  input  logic          inc,
  input  logic          dec,
  output logic [TW-1:0] nxt1,
  output logic [3:0]    nxt0
);

  localparam logic [TW-1:0] MT = TW'(MAX / 10);
  localparam logic [3:0]    MU = 4'(MAX % 10);

  logic [TW-1:0] d1;
  logic [3:0]    d0;

  // Next value: load (clamped to 00 if illegal), else step with wrap.
  always_comb begin
    nxt1 = d1;
    nxt0 = d0;
    if (load) begin
      if (bcd_ok(4'(ld1), ld0, MAX)) begin
        nxt1 = ld1;
        nxt0 = ld0;
      end else begin
        nxt1 = '0;
        nxt0 = '0;
      end
    end else if (inc) begin
      if (d1 == MT && d0 == MU) begin
        nxt1 = '0;
        nxt0 = '0;
      end else if (d0 == 4'd9) begin
        nxt1 = d1 + TW'(1);
        nxt0 = 4'd0;
      end else begin
        nxt0 = d0 + 4'd1;
      end
    end else if (dec) begin
      if (d1 == '0 && d0 == 4'd0) begin
        nxt1 = MT;
        nxt0 = MU;
      end else if (d0 == 4'd0) begin
        nxt1 = d1 - TW'(1);
        nxt0 = 4'd9;
      end else begin
        nxt0 = d0 - 4'd1;
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      d1 <= '0;
      d0 <= '0;
    end else begin
      d1 <= nxt1;
      d0 <= nxt0;
    end
  end

endmodule

// File: rtl/clock_setter.sv
// Button-driven time/alarm editor feeding the clock core load port.
// Runs on the 1 Hz tick; emits single-cycle LD_time/LD_alarm strobes.
module clock_setter
  import clock_pkg::*;
#(
  parameter int TIMEOUT = 10
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       edit_active,
  output logic [1:0] edit_field
);

  state_t state, nxt;

  logic pm, ps, pu, pd;
  logic mode_e, sel_e, up_e, down_e, any_e;
  logic st_up, st_dn;
  logic in_hour, in_min, in_edit, nxt_edit, tmo;
  logic [5:0] cnt, cnt_n;

  logic h_ld, h_inc, h_dec;
  logic m_ld, m_inc, m_dec;

  logic [1:0] sh1, eh1, ah1, lh1;
  logic [3:0] sh0, sm1, sm0;
  logic [3:0] eh0, em1, em0;
  logic [3:0] ah0, am1, am0;
  logic [3:0] lh0, lm1, lm0;

  assign mode_e = btn_mode & ~pm;
  assign sel_e  = btn_sel  & ~ps;
  assign up_e   = btn_up   & ~pu;
  assign down_e = btn_down & ~pd;
  assign any_e  = mode_e | sel_e | up_e | down_e;
  assign st_up  = up_e & ~down_e;
  assign st_dn  = down_e & ~up_e;

  assign in_hour = (state == T_HOUR) || (state == A_HOUR);
  assign in_min  = (state == T_MIN)  || (state == A_MIN);
  assign in_edit = in_hour | in_min;
  assign nxt_edit = (nxt == T_HOUR) || (nxt == T_MIN) ||
                    (nxt == A_HOUR) || (nxt == A_MIN);
  assign tmo = (cnt == 6'(TIMEOUT - 1)) && !any_e;

  // Seeds: current time from IDLE, alarm shadow from time edit.
  assign sh1 = in_edit ? ah1 : cur_h1;
  assign sh0 = in_edit ? ah0 : cur_h0;
  assign sm1 = in_edit ? am1 : cur_m1;
  assign sm0 = in_edit ? am0 : cur_m0;

  // Next state and edit-register controls; mode > sel > up/down.
  always_comb begin
    nxt   = state;
    h_ld  = 1'b0;
    m_ld  = 1'b0;
    h_inc = 1'b0;
    h_dec = 1'b0;
    m_inc = 1'b0;
    m_dec = 1'b0;
    unique case (state)
      IDLE: begin
        if (mode_e) begin
          nxt  = T_HOUR;
          h_ld = 1'b1;
          m_ld = 1'b1;
        end
      end
      T_HOUR, T_MIN, A_HOUR, A_MIN: begin
        if (mode_e) begin
          if (state == T_HOUR || state == T_MIN) begin
            nxt  = A_HOUR;
            h_ld = 1'b1;
            m_ld = 1'b1;
          end else begin
            nxt = IDLE;
          end
        end else if (sel_e) begin
          if (state == T_HOUR)      nxt = T_MIN;
          else if (state == A_HOUR) nxt = A_MIN;
          else                      nxt = LOAD;
        end else if (tmo) begin
          nxt = IDLE;
        end else begin
          h_inc = in_hour & st_up;
          h_dec = in_hour & st_dn;
          m_inc = in_min  & st_up;
          m_dec = in_min  & st_dn;
        end
      end
      LOAD:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Inactivity counter: runs only while staying in edit states.
  always_comb begin
    cnt_n = 6'd0;
    if (in_edit && nxt_edit && !any_e)
      cnt_n = cnt + 6'd1;
  end

  bcd_wrap_counter #(
    .MAX (MAX_HOUR),
    .TW  (2)
  ) u_hour (
    .clk_1s (clk_1s),
    .reset  (reset),
    .load   (h_ld),
    .ld1    (sh1),
    .ld0    (sh0),
    .inc    (h_inc),
    .dec    (h_dec),
    .nxt1   (eh1),
    .nxt0   (eh0)
  );

  bcd_wrap_counter #(
    .MAX (MAX_MIN),
    .TW  (4)
  ) u_min (
    .clk_1s (clk_1s),
    .reset  (reset),
    .load   (m_ld),
    .ld1    (sm1),
    .ld0    (sm0),
    .inc    (m_inc),
    .dec    (m_dec),
    .nxt1   (em1),
    .nxt0   (em0)
  );

  // State, edge history and inactivity counter.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pm    <= 1'b0;
      ps    <= 1'b0;
      pu    <= 1'b0;
      pd    <= 1'b0;
      cnt   <= 6'd0;
    end else begin
      state <= nxt;
      pm    <= btn_mode;
      ps    <= btn_sel;
      pu    <= btn_up;
      pd    <= btn_down;
      cnt   <= cnt_n;
    end
  end

  // Last loaded value and alarm shadow, captured entering LOAD.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      lh1 <= '0;
      lh0 <= '0;
      lm1 <= '0;
      lm0 <= '0;
      ah1 <= '0;
      ah0 <= '0;
      am1 <= '0;
      am0 <= '0;
    end else if (nxt == LOAD) begin
      lh1 <= eh1;
      lh0 <= eh0;
      lm1 <= em1;
      lm0 <= em0;
      if (state == A_MIN) begin
        ah1 <= eh1;
        ah0 <= eh0;
        am1 <= em1;
        am0 <= em0;
      end
    end
  end

  // Outputs: edit value while editing/loading, last load in IDLE.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      H_in1    <= '0;
      H_in0    <= '0;
      M_in1    <= '0;
      M_in0    <= '0;
      LD_time  <= 1'b0;
      LD_alarm <= 1'b0;
    end else begin
      if (nxt == IDLE) begin
        H_in1 <= lh1;
        H_in0 <= lh0;
        M_in1 <= lm1;
        M_in0 <= lm0;
      end else begin
        H_in1 <= eh1;
        H_in0 <= eh0;
        M_in1 <= em1;
        M_in0 <= em0;
      end
      LD_time  <= (state == T_MIN) && (nxt == LOAD);
      LD_alarm <= (state == A_MIN) && (nxt == LOAD);
    end
  end

  assign edit_active = in_edit;

  // Field indicator for the display.
  always_comb begin
    edit_field = FIELD_NONE;
    unique case (1'b1)
      in_hour: edit_field = FIELD_HOUR;
      in_min:  edit_field = FIELD_MIN;
      default: edit_field = FIELD_NONE;
    endcase
  end

endmodule
